// File: rtl/fact_driver_if.sv
// Host command/response channel plus the raw Go/N/Out/Done/Error wires of the factorial unit.
// master: host + accelerator side; slave: fact_driver.
interface fact_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_n;
  logic        rsp_err;
  logic        rsp_tmo;
  logic        fu_go;
  logic [3:0]  fu_n;
  logic [31:0] fu_out;
  logic        fu_done;
  logic        fu_error;

  modport master (
    output cmd_valid, cmd_n, rsp_ready, fu_out, fu_done, fu_error,
    input  cmd_ready, rsp_valid, rsp_data, rsp_n, rsp_err, rsp_tmo, fu_go, fu_n
  );

  modport slave (
    input  cmd_valid, cmd_n, rsp_ready, fu_out, fu_done, fu_error,
    output cmd_ready, rsp_valid, rsp_data, rsp_n, rsp_err, rsp_tmo, fu_go, fu_n
  );
endinterface

// File: rtl/fact_driver.sv
// Command-side initiator for the factorial unit: one outstanding op, Go pulse, held response.
// Optional abort counter enabled by defining FACT_DRV_TIMEOUT_EN.
module fact_driver #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  fact_driver_if.slave  bus,
  output logic          busy_o,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e      state_q;
  logic        cmd_ready_q;
  logic        fu_go_q;
  logic [3:0]  fu_n_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [3:0]  rsp_n_q;
  logic        rsp_err_q;

`ifdef FACT_DRV_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo_cnt_q;
  logic       rsp_tmo_q;
  logic       tmo_hit;
  // Hit on the last counted cycle so RESP lands once TIMEOUT_CYC cycles have elapsed.
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      fu_go_q     <= 1'b0;
      fu_n_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_n_q     <= '0;
      rsp_err_q   <= 1'b0;
`ifdef FACT_DRV_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_tmo_q   <= 1'b0;
`endif
    end else begin
      fu_go_q <= 1'b0;
`ifdef FACT_DRV_TIMEOUT_EN
      if (state_q == S_ARM || state_q == S_WAIT) tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && bus.cmd_valid) begin
            fu_n_q      <= bus.cmd_n;
            rsp_n_q     <= bus.cmd_n;
            cmd_ready_q <= 1'b0;
            state_q     <= S_ARM;
`ifdef FACT_DRV_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
          end
        end
        // Hold off Go until the previous op's Done/Error has dropped.
        S_ARM: begin
          if (!bus.fu_done && !bus.fu_error) begin
            fu_go_q <= 1'b1;
            state_q <= S_ISSUE;
          end
`ifdef FACT_DRV_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_tmo_q   <= 1'b1;
            state_q     <= S_RESP;
          end
`endif
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.fu_error) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
`ifdef FACT_DRV_TIMEOUT_EN
            rsp_tmo_q   <= 1'b0;
`endif
            state_q     <= S_RESP;
          end else if (bus.fu_done) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.fu_out;
            rsp_err_q   <= 1'b0;
`ifdef FACT_DRV_TIMEOUT_EN
            rsp_tmo_q   <= 1'b0;
`endif
            state_q     <= S_RESP;
          end
`ifdef FACT_DRV_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_tmo_q   <= 1'b1;
            state_q     <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.fu_go     = fu_go_q;
  assign bus.fu_n      = fu_n_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_n     = rsp_n_q;
  assign bus.rsp_err   = rsp_err_q;
`ifdef FACT_DRV_TIMEOUT_EN
  assign bus.rsp_tmo   = rsp_tmo_q;
`else
  assign bus.rsp_tmo   = 1'b0;
`endif
  assign busy_o  = (state_q != S_IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_fact_driver.sv
// Directed bench for fact_driver with a small factorial-unit model (Done LAT cycles after Go).
module tb_fact_driver;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fact_driver_if bus();
  logic       busy;
  logic [2:0] state;

  fact_driver #(.TIMEOUT_CYC(16)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus),
    .busy_o   (busy),
    .state_o  (state)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int go_cnt = 0;

  logic        m_done, m_err;
  logic [31:0] m_out;
  logic [3:0]  m_cnt;
  logic        mute  = 1'b0;
  logic        stale = 1'b0;

  assign bus.fu_done  = m_done | stale;
  assign bus.fu_error = m_err;
  assign bus.fu_out   = m_out;

  function automatic logic [31:0] fact_lut(input logic [3:0] n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
    return p;
  endfunction

  // Accelerator model: Done/Error raised LAT cycles after the Go cycle, dropped at the response handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0; m_err <= 1'b0; m_cnt <= '0; m_out <= '0;
    end else if (bus.fu_go) begin
      m_done <= 1'b0; m_err <= 1'b0; m_cnt <= 4'(LAT - 1);
    end else if (m_cnt == 4'd1) begin
      m_cnt <= '0;
      if (!mute) begin
        if (bus.fu_n > 4'd12) begin
          m_err <= 1'b1; m_done <= 1'b1; m_out <= 32'hDEAD_BEEF;
        end else begin
          m_done <= 1'b1; m_out <= fact_lut(bus.fu_n);
        end
      end
    end else begin
      if (m_cnt != 4'd0) m_cnt <= m_cnt - 4'd1;
      if (bus.rsp_valid && bus.rsp_ready) begin m_done <= 1'b0; m_err <= 1'b0; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  logic       prev_go = 1'b0;
  logic [2:0] prev_st = 3'd0;
  logic [3:0] prev_n  = 4'd0;
  always @(negedge clk) begin
    if (bus.fu_go) begin
      go_cnt++;
      chk("go_single", 32'(prev_go), 32'd0);
    end
    if (state inside {3'd1, 3'd2, 3'd3} && prev_st inside {3'd1, 3'd2, 3'd3})
      chk("fu_n_stable", 32'(bus.fu_n), 32'(prev_n));
    prev_go = bus.fu_go;
    prev_st = state;
    prev_n  = bus.fu_n;
  end

  task automatic run_cmd(input logic [3:0] n, input logic [31:0] exp_d, input logic exp_e,
                         input int exp_cyc, input int hold, input int stale_cyc);
    int cyc, g0, k;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_n     = n;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk("accept_ready", 32'(bus.cmd_ready), 32'd1);
    g0 = go_cnt;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.cmd_valid = 1'b0;
        chk("arm_after_accept", 32'(state), 32'd1);
        chk("fu_n", 32'(bus.fu_n), 32'(n));
        chk("busy", 32'(busy), 32'd1);
      end
      if (cyc <= stale_cyc) begin
        chk("stale_arm", 32'(state), 32'd1);
        chk("stale_nogo", 32'(bus.fu_go), 32'd0);
        if (cyc == stale_cyc) stale = 1'b0;
      end
    end while (!bus.rsp_valid && cyc < 200);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("latency", 32'(cyc), 32'(exp_cyc));
    chk("rsp_data", bus.rsp_data, exp_d);
    chk("rsp_n", 32'(bus.rsp_n), 32'(n));
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_e));
    chk("rsp_tmo", 32'(bus.rsp_tmo), 32'd0);
    chk("go_count", 32'(go_cnt - g0), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_data", bus.rsp_data, exp_d);
      chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    if (hold > 0) chk("hold_go_count", 32'(go_cnt - g0), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_state", 32'(state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_n     = 4'd0;
    bus.rsp_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fu_go", 32'(bus.fu_go), 32'd0);
    chk("rst_rsp_tmo", 32'(bus.rsp_tmo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    run_cmd(4'd5,  32'd120, 1'b0, 11, 0, 0);
    run_cmd(4'd13, 32'd0,   1'b1, 11, 0, 0);
    run_cmd(4'd3,  32'd6,   1'b0, 11, 0, 0);
    run_cmd(4'd4,  32'd24,  1'b0, 11, 20, 0);
    stale = 1'b1;
    run_cmd(4'd2,  32'd2,   1'b0, 13, 0, 3);

    mute = 1'b1;
`ifdef FACT_DRV_TIMEOUT_EN
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_n = 4'd7;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.cmd_valid = 1'b0;
    end while (!bus.rsp_valid && cyc < 100);
    chk("tmo_latency", 32'(cyc), 32'd18);
    chk("tmo_err", 32'(bus.rsp_err), 32'd1);
    chk("tmo_flag", 32'(bus.rsp_tmo), 32'd1);
    chk("tmo_data", bus.rsp_data, 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
`endif
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_n = 4'd7;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
`ifndef FACT_DRV_TIMEOUT_EN
    repeat (300) @(negedge clk);
`endif
    chk("stuck_busy", 32'(busy), 32'd1);
    chk("stuck_state", 32'(state), 32'd3);
    chk("stuck_no_rsp", 32'(bus.rsp_valid), 32'd0);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("arst_fu_n", 32'(bus.fu_n), 32'd0);
    chk("arst_fu_go", 32'(bus.fu_go), 32'd0);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_rsp_data", bus.rsp_data, 32'd0);
    chk("arst_rsp_n", 32'(bus.rsp_n), 32'd0);
    chk("arst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mute  = 1'b0;
    @(negedge clk);
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    run_cmd(4'd6, 32'd720, 1'b0, 11, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
